// File: rtl/song_pkg.sv
`default_nettype none
// ============================================================================
// Module  : song_pkg
// Purpose : Shared definitions for the song sequencer: sequencer states,
//           note-word field layout and default geometry.
// Revision: 1.0 - initial release
// ============================================================================
package song_pkg;

  // Default geometry: 4 songs of 32 note words each
  localparam int NOTES_PER_SONG_DEF = 32;
  localparam int SONG_BITS_DEF      = 2;

  // Note word layout: {note[11:6], duration[5:0]}
  localparam int WORD_W   = 12;
  localparam int NOTE_W   = 6;
  localparam int DUR_W    = 6;
  localparam int NOTE_MSB = 11;
  localparam int NOTE_LSB = 6;
  localparam int DUR_MSB  = 5;
  localparam int DUR_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    LOAD    = 3'd3,
    ARM     = 3'd4,
    PLAYING = 3'd5,
    DONE    = 3'd6
  } state_t;

  function automatic logic [NOTE_W-1:0] word_note(input logic [WORD_W-1:0] w);
    return w[NOTE_MSB:NOTE_LSB];
  endfunction

  function automatic logic [DUR_W-1:0] word_dur(input logic [WORD_W-1:0] w);
    return w[DUR_MSB:DUR_LSB];
  endfunction

endpackage
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : song_sequencer
// Purpose : Walks through the note words of the selected song in a
//           synchronous ROM (1-cycle read latency) and hands each note to an
//           external note player, waiting for it to expire before moving on.
//           A zero duration word or the last slot of the song ends playback.
//           NOTES_PER_SONG is expected to be a power of two.
// Revision: 1.0 - initial release
// ============================================================================
module song_sequencer
  import song_pkg::*;
#(
  parameter  int NOTES_PER_SONG = NOTES_PER_SONG_DEF,
  parameter  int SONG_BITS      = SONG_BITS_DEF,
  localparam int IDX_W          = $clog2(NOTES_PER_SONG),
  localparam int ADDR_W         = SONG_BITS + IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play,
  input  logic [SONG_BITS-1:0] song,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [WORD_W-1:0]    rom_data,
  output logic [NOTE_W-1:0]    note_to_load,
  output logic [DUR_W-1:0]     duration_to_load,
  output logic                 load_new_note,
  input  logic                 done_with_note,
  output logic [IDX_W-1:0]     note_index,
  output logic                 busy,
  output logic                 song_done
);

  state_t               state_q, state_d;
  logic [SONG_BITS-1:0] song_latched_q, song_latched_d;
  logic [IDX_W-1:0]     note_index_q, note_index_d;
  logic [NOTE_W-1:0]    note_q, note_d;
  logic [DUR_W-1:0]     dur_q, dur_d;
  logic                 song_done_q, song_done_d;
  logic                 load_d;
  logic                 busy_w;
  logic                 song_change_w;
  logic                 last_note_w;

  assign busy_w        = (state_q != IDLE) && (state_q != DONE);
  assign song_change_w = busy_w && (song != song_latched_q);
  assign last_note_w   = (note_index_q == IDX_W'(NOTES_PER_SONG - 1));

  // Next-state and strobe logic; a song change outranks everything incl. pause
  always_comb begin
    state_d        = state_q;
    song_latched_d = song_latched_q;
    note_index_d   = note_index_q;
    note_d         = note_q;
    dur_d          = dur_q;
    load_d         = 1'b0;
    if (song_change_w) begin
      song_latched_d = song;
      note_index_d   = '0;
      state_d        = FETCH;
    end else begin
      case (state_q)
        IDLE: begin
          if (play) begin
            song_latched_d = song;
            note_index_d   = '0;
            state_d        = FETCH;
          end
        end
        // ROM address is already on the bus; data is valid one cycle later
        FETCH: begin
          if (play) state_d = DECODE;
        end
        DECODE: begin
          if (play) begin
            if (word_dur(rom_data) == '0) begin
              state_d = DONE;
            end else begin
              note_d  = word_note(rom_data);
              dur_d   = word_dur(rom_data);
              state_d = LOAD;
            end
          end
        end
        // Strobe only fires on the cycle LOAD is left, so a pause cannot
        // stretch or lose it
        LOAD: begin
          if (play) begin
            load_d  = 1'b1;
            state_d = ARM;
          end
        end
        // Ignore a done level left over from the previous note
        ARM: begin
          if (play && !done_with_note) state_d = PLAYING;
        end
        PLAYING: begin
          if (play && done_with_note) begin
            if (last_note_w) begin
              state_d = DONE;
            end else begin
              note_index_d = note_index_q + IDX_W'(1);
              state_d      = FETCH;
            end
          end
        end
        DONE: begin
          if (!play) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    song_done_d = (state_d == DONE) && (state_q != DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      song_latched_q <= '0;
      note_index_q   <= '0;
      note_q         <= '0;
      dur_q          <= '0;
      song_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      song_latched_q <= song_latched_d;
      note_index_q   <= note_index_d;
      note_q         <= note_d;
      dur_q          <= dur_d;
      song_done_q    <= song_done_d;
    end
  end

  assign rom_addr         = {song_latched_q, note_index_q};
  assign note_to_load     = note_q;
  assign duration_to_load = dur_q;
  assign load_new_note    = load_d;
  assign note_index       = note_index_q;
  assign busy             = busy_w;
  assign song_done        = song_done_q;

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_song_sequencer
// Purpose : Self-checking bench for song_sequencer with a ROM model, a simple
//           note player model and a load scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_song_sequencer;
  import song_pkg::*;

  localparam int N  = 32;
  localparam int SB = 2;
  localparam int IW = 5;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          play = 1'b0;
  logic [SB-1:0] song = '0;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_data;
  logic [5:0]    note_to_load;
  logic [5:0]    duration_to_load;
  logic          load_new_note;
  logic          done_with_note;
  logic [IW-1:0] note_index;
  logic          busy;
  logic          song_done;

  song_sequencer #(.NOTES_PER_SONG(N), .SONG_BITS(SB)) dut (
    .clk              (clk),
    .reset            (reset),
    .play             (play),
    .song             (song),
    .rom_addr         (rom_addr),
    .rom_data         (rom_data),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .done_with_note   (done_with_note),
    .note_index       (note_index),
    .busy             (busy),
    .song_done        (song_done)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM, one cycle read latency
  logic [11:0] rom [0:127];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Note player model: done drops on load, rises after 'duration' cycles
  logic auto_np  = 1'b1;
  logic man_done = 1'b0;
  logic np_done  = 1'b1;
  int   np_cnt   = 0;
  always @(posedge clk) begin
    if (load_new_note) begin
      np_cnt  <= int'(duration_to_load);
      np_done <= 1'b0;
    end else if (!np_done) begin
      if (np_cnt <= 1) np_done <= 1'b1;
      else             np_cnt  <= np_cnt - 1;
    end
  end
  assign done_with_note = auto_np ? np_done : man_done;

  typedef struct packed {
    logic [5:0] note;
    logic [5:0] dur;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;
  int   n_loads  = 0;
  int   n_song_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: every load pops the next expected note
  initial forever begin
    @(negedge clk);
    if (reset && load_new_note) begin
      n_loads++;
      check("sb_load_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_note", 32'(note_to_load), 32'(e.note));
        check("sb_dur", 32'(duration_to_load), 32'(e.dur));
      end
    end
    if (song_done) n_song_done++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic measure_latency(output int lat);
    lat = 0;
    while (!load_new_note && lat < 20) begin
      tick(1);
      lat++;
    end
  endtask

  task automatic start_and_measure(output int lat);
    tick(1);
    play = 1'b1;
    measure_latency(lat);
  endtask

  task automatic wait_loads(input int target, input int budget, input string name);
    int c = 0;
    while (n_loads < target && c < budget) begin
      tick(1);
      c++;
    end
    check(name, 32'(n_loads >= target), 1);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int c = 0;
    while (n_song_done < target && c < budget) begin
      tick(1);
      c++;
    end
    check(name, 32'(n_song_done >= target), 1);
  endtask

  task automatic wait_state(input state_t s, input int budget, input string name);
    int c = 0;
    while (dut.state_q != s && c < budget) begin
      tick(1);
      c++;
    end
    check(name, 32'(dut.state_q), 32'(s));
  endtask

  task automatic clear_song(input logic [1:0] s);
    for (int i = 0; i < N; i++) rom[{s, 5'(i)}] = 12'd0;
  endtask

  task automatic push_exp(input logic [11:0] w);
    exp_q.push_back('{note: w[11:6], dur: w[5:0]});
  endtask

  typedef struct {
    logic [1:0]  song;
    logic [11:0] w0;
    logic [11:0] w1;
    logic [11:0] w2;
    int          nloads;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat;
    int base_l;
    int base_d;
    logic [11:0] ws[3];

    #600000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base_l;
    int base_d;
    logic [11:0] ws[3];

    for (int i = 0; i < 128; i++) rom[i] = 12'd0;

    vecs[0] = '{2'd0, {6'd10, 6'd4},  {6'd12, 6'd2}, 12'd0,         2};
    vecs[1] = '{2'd1, {6'd0,  6'd3},  {6'd63, 6'd1}, 12'd0,         2};
    vecs[2] = '{2'd2, {6'd5,  6'd0},  {6'd9,  6'd9}, 12'd0,         0};
    vecs[3] = '{2'd3, {6'd33, 6'd63}, {6'd1,  6'd1}, {6'd7, 6'd2},  3};

    // ---------------- reset values ----------------
    tick(2);
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_note", 32'(note_to_load), 0);
    check("rst_dur", 32'(duration_to_load), 0);
    check("rst_load", 32'(load_new_note), 0);
    check("rst_song_done", 32'(song_done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_note_index", 32'(note_index), 0);
    reset = 1'b1;
    tick(2);

    // ---------------- table-driven songs ----------------
    for (int v = 0; v < 4; v++) begin
      clear_song(vecs[v].song);
      rom[{vecs[v].song, 5'd0}] = vecs[v].w0;
      rom[{vecs[v].song, 5'd1}] = vecs[v].w1;
      rom[{vecs[v].song, 5'd2}] = vecs[v].w2;
      ws[0] = vecs[v].w0;
      ws[1] = vecs[v].w1;
      ws[2] = vecs[v].w2;
      for (int k = 0; k < vecs[v].nloads; k++) push_exp(ws[k]);
      song   = vecs[v].song;
      base_l = n_loads;
      base_d = n_song_done;
      start_and_measure(lat);
      if (vecs[v].nloads > 0) check("vec_latency", 32'(lat), 3);
      wait_done(base_d + 1, 400, "vec_song_done_seen");
      tick(3);
      check("vec_done_pulses", 32'(n_song_done - base_d), 1);
      check("vec_busy_in_done", 32'(busy), 0);
      check("vec_load_count", 32'(n_loads - base_l), 32'(vecs[v].nloads));
      check("vec_sb_empty", 32'(exp_q.size()), 0);
      play = 1'b0;
      tick(2);
      check("vec_idle", 32'(dut.state_q), 32'(IDLE));
    end

    // ---------------- stale done held high ----------------
    clear_song(2'd0);
    rom[{2'd0, 5'd0}] = {6'd10, 6'd4};
    rom[{2'd0, 5'd1}] = {6'd12, 6'd2};
    push_exp({6'd10, 6'd4});
    push_exp({6'd12, 6'd2});
    song     = 2'd0;
    auto_np  = 1'b0;
    man_done = 1'b1;
    base_l   = n_loads;
    base_d   = n_song_done;
    start_and_measure(lat);
    check("stale_latency", 32'(lat), 3);
    tick(6);
    check("stale_no_second_load", 32'(n_loads - base_l), 1);
    check("stale_in_arm", 32'(dut.state_q), 32'(ARM));
    man_done = 1'b0;
    tick(3);
    check("stale_playing", 32'(dut.state_q), 32'(PLAYING));
    check("stale_no_load_low", 32'(n_loads - base_l), 1);
    man_done = 1'b1;
    wait_loads(base_l + 2, 12, "stale_second_load");
    tick(3);
    check("stale_hold_after_2nd", 32'(n_loads - base_l), 2);
    man_done = 1'b0;
    tick(2);
    man_done = 1'b1;
    wait_done(base_d + 1, 12, "stale_song_done");
    auto_np = 1'b1;
    play    = 1'b0;
    tick(2);

    // ---------------- pause in PLAYING and FETCH ----------------
    clear_song(2'd1);
    rom[{2'd1, 5'd0}] = {6'd20, 6'd3};
    rom[{2'd1, 5'd1}] = {6'd21, 6'd3};
    rom[{2'd1, 5'd2}] = {6'd22, 6'd2};
    push_exp({6'd20, 6'd3});
    push_exp({6'd21, 6'd3});
    push_exp({6'd22, 6'd2});
    song   = 2'd1;
    base_l = n_loads;
    base_d = n_song_done;
    start_and_measure(lat);
    wait_loads(base_l + 1, 10, "pause_first_load");
    tick(1);
    check("pause_in_playing", 32'(dut.state_q), 32'(PLAYING));
    play = 1'b0;
    tick(10);
    check("pause_play_no_load", 32'(n_loads - base_l), 1);
    check("pause_play_hold", 32'(dut.state_q), 32'(PLAYING));
    check("pause_play_note_held", 32'(note_to_load), 20);
    play = 1'b1;
    wait_loads(base_l + 2, 20, "pause_resume_load");
    wait_state(FETCH, 30, "pause_reach_fetch");
    play = 1'b0;
    tick(10);
    check("pause_fetch_no_load", 32'(n_loads - base_l), 2);
    check("pause_fetch_hold", 32'(dut.state_q), 32'(FETCH));
    check("pause_fetch_addr", 32'(rom_addr), 32'({2'd1, 5'd2}));
    play = 1'b1;
    wait_done(base_d + 1, 40, "pause_song_done");
    check("pause_load_count", 32'(n_loads - base_l), 3);
    play = 1'b0;
    tick(2);

    // ---------------- song switch mid-note ----------------
    clear_song(2'd1);
    for (int i = 0; i < 10; i++) rom[{2'd1, 5'(i)}] = {6'(i + 1), 6'd2};
    clear_song(2'd2);
    rom[{2'd2, 5'd0}] = {6'd40, 6'd2};
    rom[{2'd2, 5'd1}] = {6'd41, 6'd2};
    for (int i = 0; i < 6; i++) push_exp({6'(i + 1), 6'd2});
    song   = 2'd1;
    base_l = n_loads;
    base_d = n_song_done;
    start_and_measure(lat);
    wait_loads(base_l + 6, 80, "switch_six_loads");
    tick(1);
    check("switch_index_before", 32'(note_index), 5);
    push_exp({6'd40, 6'd2});
    push_exp({6'd41, 6'd2});
    song = 2'd2;
    tick(1);
    check("switch_state_fetch", 32'(dut.state_q), 32'(FETCH));
    check("switch_index_zero", 32'(note_index), 0);
    check("switch_rom_addr", 32'(rom_addr), 32'({2'd2, 5'd0}));
    wait_done(base_d + 1, 60, "switch_song_done");
    check("switch_load_count", 32'(n_loads - base_l), 8);
    play = 1'b0;
    tick(2);

    // ---------------- full 32-note song, no end marker ----------------
    for (int i = 0; i < N; i++) begin
      rom[{2'd3, 5'(i)}] = {6'(i + 1), 6'd1};
      push_exp({6'(i + 1), 6'd1});
    end
    song   = 2'd3;
    base_l = n_loads;
    base_d = n_song_done;
    start_and_measure(lat);
    wait_done(base_d + 1, 600, "full_song_done");
    tick(10);
    check("full_load_count", 32'(n_loads - base_l), 32);
    check("full_done_pulses", 32'(n_song_done - base_d), 1);
    check("full_busy", 32'(busy), 0);
    check("full_last_index", 32'(note_index), 31);
    check("full_sb_empty", 32'(exp_q.size()), 0);
    play = 1'b0;
    tick(2);

    // ---------------- reset during ARM ----------------
    clear_song(2'd0);
    rom[{2'd0, 5'd0}] = {6'd10, 6'd4};
    rom[{2'd0, 5'd1}] = {6'd12, 6'd2};
    push_exp({6'd10, 6'd4});
    song   = 2'd0;
    base_l = n_loads;
    base_d = n_song_done;
    start_and_measure(lat);
    wait_loads(base_l + 1, 10, "rstarm_first_load");
    check("rstarm_in_arm", 32'(dut.state_q), 32'(ARM));
    reset = 1'b0;
    #1;
    check("rstarm_load", 32'(load_new_note), 0);
    check("rstarm_busy", 32'(busy), 0);
    check("rstarm_song_done", 32'(song_done), 0);
    check("rstarm_note", 32'(note_to_load), 0);
    check("rstarm_dur", 32'(duration_to_load), 0);
    check("rstarm_index", 32'(note_index), 0);
    check("rstarm_rom_addr", 32'(rom_addr), 0);
    tick(2);
    check("rstarm_no_load_in_reset", 32'(n_loads - base_l), 1);
    push_exp({6'd10, 6'd4});
    push_exp({6'd12, 6'd2});
    tick(1);
    reset = 1'b1;
    measure_latency(lat);
    check("rstarm_latency", 32'(lat), 3);
    check("rstarm_first_index", 32'(note_index), 0);
    wait_done(base_d + 1, 60, "rstarm_song_done");
    check("rstarm_load_count", 32'(n_loads - base_l), 3);
    play = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter NOTES_PER_SONG, default 32, meaning number of note words per song; must be a power of two.
REQ-002 SHALL have parameter SONG_BITS, default 2, meaning the song-select width (4 songs).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all flops on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port play, input, 1 bit: high to run, low to pause.
REQ-006 SHALL have port song, input, SONG_BITS bits: song select.
REQ-007 SHALL have port rom_addr, output, SONG_BITS+log2(NOTES_PER_SONG) bits: {song_latched, note_index} to a synchronous song ROM with 1-cycle read latency.
REQ-008 SHALL have port rom_data, input, 12 bits: {note[11:6], duration[5:0]}.
REQ-009 SHALL have port note_to_load, output, 6 bits: note for note_player.
REQ-010 SHALL have port duration_to_load, output, 6 bits: duration in beats for note_player.
REQ-011 SHALL have port load_new_note, output, 1 bit: one-cycle load strobe to note_player.
REQ-012 SHALL have port done_with_note, input, 1 bit: level from note_player, high while the current note has expired.
REQ-013 SHALL have port note_index, output, log2(NOTES_PER_SONG) bits: index of the current note.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE or DONE.
REQ-015 SHALL have port song_done, output, 1 bit: one-cycle pulse at end of song.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DECODE, LOAD, ARM, PLAYING, DONE.
REQ-017 In IDLE with play=1, SHALL latch song into song_latched, clear note_index to 0, and go to FETCH.
REQ-018 FETCH SHALL present rom_addr and go to DECODE next cycle.
REQ-019 In DECODE, SHALL go to DONE if rom_data duration==0 (end marker); otherwise register note/duration into note_to_load/duration_to_load and go to LOAD.
REQ-020 LOAD SHALL assert load_new_note for exactly one cycle and go to ARM.
REQ-021 ARM SHALL wait until done_with_note==0, then go to PLAYING, so a stale done level from the previous note is ignored.
REQ-022 PLAYING SHALL wait for done_with_note==1, then go to DONE if note_index==NOTES_PER_SONG-1; otherwise increment note_index and go to FETCH.
REQ-023 Latency SHALL be exactly: play rising in IDLE at cycle 0 -> FETCH at 1 -> DECODE at 2 -> load_new_note high at cycle 3.
REQ-024 Note value 0 (rest) SHALL be passed through unchanged, with its duration honoured.
REQ-025 With play=0 in FETCH through PLAYING, the FSM SHALL hold state, load_new_note SHALL stay 0, and registered outputs SHALL hold; a ROM read in FETCH SHALL be reissued on resume (FETCH->DECODE is re-entered).
REQ-026 If song differs from song_latched in any busy state, SHALL relatch song, clear note_index, and go to FETCH next cycle; this has priority over all other transitions and over pause.
REQ-027 DONE SHALL pulse song_done on entry only, then hold until play==0, then go to IDLE.
REQ-028 note_index SHALL never wrap; end-of-song is taken before wrap.

Reset
REQ-029 On reset low, asynchronously: state=IDLE, note_index=0, song_latched=0, note_to_load=0, duration_to_load=0, load_new_note=0, song_done=0, busy=0.
REQ-030 Reset mid-note SHALL abandon the song; a load SHALL NOT be issued until a fresh IDLE->FETCH sequence.

Structure
REQ-031 State encoding, note-word field positions, and default NOTES_PER_SONG/SONG_BITS SHALL live in shared package song_pkg.
REQ-032 SHALL be a single module with no sub-module; the song ROM and note_player are instantiated by the parent.

Verification
REQ-033 ROM song 0 = {(10,4),(12,2),(0,0)}, play=1 at cycle 0 -> load at cycle 3 with note 10 / duration 4; after done, load with 12/2; then song_done pulse, busy=0.
REQ-034 done_with_note held high through LOAD and two further cycles -> no second load until done falls then rises.
REQ-035 play dropped for 10 cycles in PLAYING and in FETCH -> no load during pause; the next load carries the correct next note on resume.
REQ-036 Song switched 1->2 mid-note at index 5 -> within 1 cycle state=FETCH, note_index=0, rom_addr = {2,0}.
REQ-037 Song of 32 notes with no end marker -> after the 32nd done, song_done pulses and no 33rd load occurs.
REQ-038 Reset asserted during ARM -> all outputs 0 immediately; after release with play=1, the first load arrives 3 cycles later with note index 0.
